// File: rtl/io_input_conditioner_if.sv
// rtl/io_input_conditioner_if.sv - pin-side and core-side signal bundle of the input conditioner
interface io_input_conditioner_if #(
    parameter int NUM_IN = 12
);
    logic [NUM_IN-1:0] RawIn;
    logic [NUM_IN-1:0] StickyClr;
    logic [NUM_IN-1:0] Level;
    logic [NUM_IN-1:0] RisePulse;
    logic [NUM_IN-1:0] FallPulse;
    logic [NUM_IN-1:0] Sticky;
    logic              AnyEvent;

    modport master (
        output RawIn, StickyClr,
        input  Level, RisePulse, FallPulse, Sticky, AnyEvent
    );

    modport slave (
        input  RawIn, StickyClr,
        output Level, RisePulse, FallPulse, Sticky, AnyEvent
    );
endinterface

// File: rtl/io_input_conditioner.sv
// rtl/io_input_conditioner.sv - per-channel invert, synchronise, debounce, edge pulses, sticky flags
// Optional auto-repeat of RisePulse while held: define IO_INPUT_CONDITIONER_REPEAT_EN.
module io_input_conditioner #(
    parameter int                 NUM_IN          = 12,
    parameter logic [NUM_IN-1:0]  ACTIVE_LOW_MASK = 12'b1100_0000_0000,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 500000,
    parameter int                 REPEAT_DELAY    = 25000000,
    parameter int                 REPEAT_PERIOD   = 5000000
) (
    input  logic                  Clock,
    input  logic                  Rst,
    io_input_conditioner_if.slave io
);
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("io_input_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("io_input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("io_input_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [NUM_IN-1:0] sync_chain [SYNC_STAGES];
    logic [NUM_IN-1:0] cond_in;
    logic [NUM_IN-1:0] sync;
    logic [NUM_IN-1:0] level_q;
    logic [NUM_IN-1:0] rise_q;
    logic [NUM_IN-1:0] fall_q;
    logic [NUM_IN-1:0] sticky_q;
    logic              any_q;
    logic [CW-1:0]     cnt [NUM_IN];

    logic [NUM_IN-1:0] accept;
    logic [NUM_IN-1:0] rise_d;
    logic [NUM_IN-1:0] fall_d;
    logic [NUM_IN-1:0] sticky_d;

    assign cond_in = io.RawIn ^ ACTIVE_LOW_MASK;
    assign sync    = sync_chain[SYNC_STAGES-1];

`ifdef IO_INPUT_CONDITIONER_REPEAT_EN
    localparam int            RMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW       = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]     rep_cnt [NUM_IN];
    logic [NUM_IN-1:0] repeating;
    logic [NUM_IN-1:0] rep_fire;
`endif

    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            accept[i] = (sync[i] != level_q[i]) && (cnt[i] == CNT_LAST);
        end
        rise_d = accept & ~level_q;
        fall_d = accept & level_q;
`ifdef IO_INPUT_CONDITIONER_REPEAT_EN
        rep_fire = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            rep_fire[i] = level_q[i] && !fall_d[i] &&
                          (rep_cnt[i] == (repeating[i] ? PER_LAST : DLY_LAST));
        end
        rise_d = rise_d | rep_fire;
`endif
        // A clear landing on either the set edge or the pulse cycle loses to the set.
        sticky_d = rise_d | rise_q | (sticky_q & ~io.StickyClr);
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_chain[s] <= '0;
            end
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= '0;
            end
            level_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            sticky_q <= '0;
            any_q    <= 1'b0;
        end else begin
            sync_chain[0] <= cond_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_chain[s] <= sync_chain[s-1];
            end
            for (int i = 0; i < NUM_IN; i++) begin
                if ((sync[i] == level_q[i]) || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            level_q  <= level_q ^ accept;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
            any_q    <= |(rise_d | fall_d);
        end
    end

`ifdef IO_INPUT_CONDITIONER_REPEAT_EN
    always_ff @(posedge Clock) begin
        if (Rst) begin
            for (int i = 0; i < NUM_IN; i++) begin
                rep_cnt[i] <= '0;
            end
            repeating <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (!level_q[i] || fall_d[i]) begin
                    rep_cnt[i]   <= '0;
                    repeating[i] <= 1'b0;
                end else if (rep_fire[i]) begin
                    rep_cnt[i]   <= '0;
                    repeating[i] <= 1'b1;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + RW'(1);
                end
            end
        end
    end
`endif

    assign io.Level     = level_q;
    assign io.RisePulse = rise_q;
    assign io.FallPulse = fall_q;
    assign io.Sticky    = sticky_q;
    assign io.AnyEvent  = any_q;
endmodule
